// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the 32-bit ALU sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Ops that run the adder with B inverted and carry-in forced to 1 on the low pass.
    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

    // Only ADD/SUB report carry and overflow.
    function automatic logic op_is_addsub(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // Reserved encodings report all flags as 0.
    function automatic logic op_is_defined(input logic [2:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu32_seq_ctrl.sv
// Sequences a 32-bit ALU op over one external 16-bit slice: LO pass, HI pass, extra FIX pass for SLT.
// Latency: done in the 3rd cycle after accept (4th for SLT); one op per 3 (4) cycles back-to-back.
// Backpressure: start is taken only in IDLE or DONE; start while busy is dropped, no queueing.
module alu32_seq_ctrl
    import alu_pkg::*;
#(
    parameter int HALF_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2*HALF_W-1:0] a,
    input  logic [2*HALF_W-1:0] b,
    input  logic [2:0]          alu_op,
    output logic                busy,
    output logic                done,
    output logic [2*HALF_W-1:0] result,
    output logic                zero,
    output logic                overflow,
    output logic                carry_out,
    output logic [HALF_W-1:0]   sl_a,
    output logic [HALF_W-1:0]   sl_b,
    output logic                sl_c0,
    output logic                sl_less,
    output logic [2:0]          sl_op,
    input  logic [HALF_W-1:0]   sl_ri,
    input  logic                sl_co,
    input  logic                sl_nz,
    input  logic                sl_v,
    input  logic                sl_set
);

    state_t                state_q, state_d;
    logic [2*HALF_W-1:0]   a_q, b_q;
    logic [2:0]            op_q;
    logic [HALF_W-1:0]     res_lo;
    logic                  nz_lo;
    logic                  cy_q;
    logic                  set_q;
    logic                  load;

    assign busy = (state_q == ST_LO) || (state_q == ST_HI) || (state_q == ST_FIX);
    assign done = (state_q == ST_DONE);

    // Next-state decode, accept strobe and the slice-drive mux; everything idles at 0.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        sl_a    = '0;
        sl_b    = '0;
        sl_c0   = 1'b0;
        sl_less = 1'b0;
        sl_op   = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                sl_a    = a_q[HALF_W-1:0];
                sl_b    = b_q[HALF_W-1:0];
                sl_c0   = op_is_sub(op_q);
                sl_op   = op_q;
                state_d = ST_HI;
            end
            ST_HI: begin
                sl_a    = a_q[2*HALF_W-1:HALF_W];
                sl_b    = b_q[2*HALF_W-1:HALF_W];
                sl_c0   = cy_q;
                sl_op   = op_q;
                state_d = (op_q == ALU_SLT) ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                // Low half again: result bit 0 becomes the sign-compare bit, the rest are 0.
                sl_a    = a_q[HALF_W-1:0];
                sl_b    = b_q[HALF_W-1:0];
                sl_c0   = 1'b1;
                sl_less = set_q;
                sl_op   = op_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand latch, per-pass captures, and the visible result loaded on the edge into DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 3'b000;
            res_lo    <= '0;
            nz_lo     <= 1'b0;
            cy_q      <= 1'b0;
            set_q     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= alu_op;
            end
            case (state_q)
                ST_LO: begin
                    res_lo <= sl_ri;
                    nz_lo  <= sl_nz;
                    cy_q   <= sl_co;
                end
                ST_HI: begin
                    set_q <= sl_set;
                    // SLT publishes after FIX; the HI half of an SLT result is always 0.
                    if (op_q != ALU_SLT) begin
                        result    <= {sl_ri, res_lo};
                        zero      <= op_is_defined(op_q) & ~(nz_lo | sl_nz);
                        overflow  <= op_is_addsub(op_q) & sl_v;
                        carry_out <= op_is_addsub(op_q) & sl_co;
                    end
                end
                ST_FIX: begin
                    res_lo    <= sl_ri;
                    nz_lo     <= sl_nz;
                    result    <= {{HALF_W{1'b0}}, sl_ri};
                    zero      <= ~sl_nz;
                    overflow  <= 1'b0;
                    carry_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// Bench for the ALU sequencer with a behavioural 16-bit MSB slice attached to its slice ports.
// Latency: measured in cycles from the first busy cycle to the done cycle inclusive.
// Backpressure: exercises back-to-back accepts, start while busy, and reset mid-operation.
module tb_alu32_seq_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic [2:0]  alu_op;
    logic        busy, done, zero, overflow, carry_out;
    logic [31:0] result;
    logic [15:0] sl_a, sl_b, sl_ri;
    logic        sl_c0, sl_less, sl_co, sl_nz, sl_v, sl_set;
    logic [2:0]  sl_op;

    int vectors;
    int miscompares;

    alu32_seq_ctrl #(.HALF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_op(alu_op),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .overflow(overflow), .carry_out(carry_out),
        .sl_a(sl_a), .sl_b(sl_b), .sl_c0(sl_c0), .sl_less(sl_less), .sl_op(sl_op),
        .sl_ri(sl_ri), .sl_co(sl_co), .sl_nz(sl_nz), .sl_v(sl_v), .sl_set(sl_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice model: 16-bit bit-slice ALU, MSB variant with overflow and signed-less-than outputs.
    logic [15:0] sm_bb;
    logic [16:0] sm_sum;
    logic        sm_ovf;
    always_comb begin
        sm_bb  = sl_op[2] ? ~sl_b : sl_b;
        sm_sum = {1'b0, sl_a} + {1'b0, sm_bb} + {16'd0, sl_c0};
        sm_ovf = (sl_a[15] == sm_bb[15]) && (sm_sum[15] != sl_a[15]);
        case (sl_op)
            ALU_AND: sl_ri = sl_a & sl_b;
            ALU_OR:  sl_ri = sl_a | sl_b;
            ALU_ADD, ALU_SUB: sl_ri = sm_sum[15:0];
            ALU_SLT: sl_ri = {15'd0, sl_less};
            default: sl_ri = 16'd0;
        endcase
        sl_co  = sm_sum[16];
        sl_v   = sm_ovf;
        sl_set = sm_sum[15] ^ sm_ovf;
        sl_nz  = |sl_ri;
    end

    // Whole-word reference: what a 32-bit ALU returns for each op.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output logic v, output logic c);
        logic [32:0] s;
        r = 32'd0; z = 1'b0; v = 1'b0; c = 1'b0;
        case (op)
            ALU_AND: r = x & y;
            ALU_OR:  r = x | y;
            ALU_ADD: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[31:0]; c = s[32];
                v = (x[31] == y[31]) && (r[31] != x[31]);
            end
            ALU_SUB: begin
                s = {1'b0, x} + {1'b0, ~y} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (x[31] != y[31]) && (r[31] != x[31]);
            end
            ALU_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: ;
        endcase
        if (op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT})
            z = (r == 32'd0);
    endtask

    // Issue one op from IDLE/DONE and wait (bounded) for done; returns what was seen.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] r, output logic z,
                         output logic v, output logic c);
        @(negedge clk);
        start = 1'b1; a = x; b = y; alu_op = op;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r = result; z = zero; v = overflow; c = carry_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; alu_op = ALU_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, zero, overflow, carry_out} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/done/zero/v/c=%b want 00000",
                     {busy, done, zero, overflow, carry_out});
        end
        vectors++;
        if (result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 00000000", result);
        end
        vectors++;
        if ({sl_a, sl_b, sl_c0, sl_less, sl_op} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_slice: got a=%h b=%h c0=%b less=%b op=%b want all 0",
                     sl_a, sl_b, sl_c0, sl_less, sl_op);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLT, ALU_AND, ALU_OR, 3'b011};
        logic [31:0] xs  [7] = '{32'h0000FFFF, 32'h80000000, 32'hFFFFFFFF, 32'd5,
                                 32'hF0F0F0F0, 32'h0, 32'h00000123};
        logic [31:0] ys  [7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd3,
                                 32'h0FF00FF0, 32'h0, 32'h00000456};
        for (int i = 0; i < 7; i++) begin
            int lat, elat;
            logic [31:0] r, er;
            logic z, v, c, ez, ev, ec;
            model(ops[i], xs[i], ys[i], er, ez, ev, ec);
            elat = (ops[i] == ALU_SLT) ? 4 : 3;
            do_op(ops[i], xs[i], ys[i], lat, r, z, v, c);
            vectors++;
            if (lat !== elat) begin
                miscompares++;
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat);
            end
            vectors++;
            if (r !== er) begin
                miscompares++;
                $display("FAIL dir%0d_result: got %h want %h", i, r, er);
            end
            vectors++;
            if ({z, v, c} !== {ez, ev, ec}) begin
                miscompares++;
                $display("FAIL dir%0d_flags: zvc got %b want %b", i, {z, v, c}, {ez, ev, ec});
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  opset  [8] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
                                    3'b011, 3'b100, 3'b101};
        logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                    32'h7FFFFFFF, 32'h0000FFFF};
        for (int i = 0; i < 60; i++) begin
            int lat, elat;
            logic [2:0]  op;
            logic [31:0] x, y, r, er;
            logic z, v, c, ez, ev, ec;
            op = opset[$urandom_range(0, 7)];
            x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            model(op, x, y, er, ez, ev, ec);
            elat = (op == ALU_SLT) ? 4 : 3;
            do_op(op, x, y, lat, r, z, v, c);
            vectors++;
            if (lat !== elat || r !== er || {z, v, c} !== {ez, ev, ec}) begin
                miscompares++;
                $display("FAIL rnd%0d op=%b a=%h b=%h: got lat=%0d r=%h zvc=%b want lat=%0d r=%h zvc=%b",
                         i, op, x, y, lat, r, {z, v, c}, elat, er, {ez, ev, ec});
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] r1, r2;
        logic z1, v1, c1, z2, v2, c2;
        model(ALU_ADD, 32'h00001234, 32'h0000FFFF, r1, z1, v1, c1);
        model(ALU_SUB, 32'h80000000, 32'h00000001, r2, z2, v2, c2);
        @(negedge clk);
        start = 1'b1; a = 32'h00001234; b = 32'h0000FFFF; alu_op = ALU_ADD;
        @(posedge clk);
        @(negedge clk);
        // start stays high; these operands must wait for the DONE-cycle accept.
        a = 32'h80000000; b = 32'h00000001; alu_op = ALU_SUB;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 3 || result !== r1) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d r=%h want lat=3 r=%h", lat, result, r1);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 3 || result !== r2 || {zero, overflow, carry_out} !== {z2, v2, c2}) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d r=%h zvc=%b want lat=3 r=%h zvc=%b",
                     lat, result, {zero, overflow, carry_out}, r2, {z2, v2, c2});
        end
    endtask

    task automatic test_busy_ignore();
        int lat, pulses;
        logic [31:0] r1;
        logic z1, v1, c1;
        model(ALU_ADD, 32'h0F0F0F0F, 32'h01010101, r1, z1, v1, c1);
        @(negedge clk);
        start = 1'b1; a = 32'h0F0F0F0F; b = 32'h01010101; alu_op = ALU_ADD;
        @(posedge clk);
        @(negedge clk);
        // In LO: a fresh request arrives and must be ignored.
        start = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; alu_op = ALU_SLT;
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 3 || result !== r1) begin
            miscompares++;
            $display("FAIL busy_ignore: got lat=%0d r=%h want lat=3 r=%h", lat, result, r1);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0 || result !== r1) begin
            miscompares++;
            $display("FAIL busy_no_requeue: got %0d busy/done cycles r=%h want 0 r=%h",
                     pulses, result, r1);
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        logic [31:0] r;
        logic z, v, c;
        do_op(ALU_ADD, 32'h12345678, 32'h11111111, lat, r, z, v, c);
        @(negedge clk);
        start = 1'b1; a = 32'hAAAA5555; b = 32'h5555AAAA; alu_op = ALU_OR;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, zero, overflow, carry_out} !== 5'b0 || result !== 32'd0 || sl_op !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid: got bdzvc=%b r=%h sl_op=%b want 00000 00000000 000",
                     {busy, done, zero, overflow, carry_out}, result, sl_op);
        end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_dropped: got %0d busy/done cycles want 0", pulses);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
